wake_decision_ctrl: RTL and testbench

//  Parametrised wake-up decision block behind the median-filter image reader; successor to the single-threshold comparator.

---
 rtl/median_filter_pkg.sv | 29 ++
 rtl/frame_history_window.sv | 58 +++++
 rtl/wake_decision_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_wake_decision_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_filter_pkg.sv
// Shared encodings and defaults for the wake-up decision logic
// behind the median-filter image reader.
package median_filter_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CONSEC = 2'd1,
        MODE_KOFN   = 2'd2,
        MODE_HYST   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAKE    = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam int DEF_CNT_W   = 13;
    localparam int DEF_MAX_WIN = 4800;

    // K of zero means one frame; K beyond the history depth is capped.
    function automatic int clamp_k(input int k, input int n);
        if (k == 0) return 1;
        if (k > n) return n;
        return k;
    endfunction

endpackage

// File: rtl/frame_history_window.sv
// Above-threshold frame history: shift register, run counter
// and popcount, with hit flags computed on the incoming frame.
module frame_history_window
    import median_filter_pkg::*;
#(
    parameter int N  = 8,
    parameter int KW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          shiftEn,
    input  logic          bitIn,
    input  logic [KW-1:0] K,
    output logic          consecHit,
    output logic          kofnHit
);

    logic [N-1:0]  hist;
    logic [N-1:0]  hist_next;
    logic [KW-1:0] consec;
    logic [KW-1:0] consec_next;
    logic [KW-1:0] pop;

    always_comb begin
        hist_next   = hist;
        consec_next = consec;
        if (shiftEn) begin
            hist_next = {hist[N-2:0], bitIn};
            if (!bitIn) begin
                consec_next = '0;
            end else if (consec != KW'(N)) begin
                consec_next = consec + 1'b1;
            end
        end
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + KW'(hist_next[i]);
        end
    end

    assign consecHit = (consec_next >= K);
    assign kofnHit   = (pop >= K);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist   <= '0;
            consec <= '0;
        end else if (clear) begin
            hist   <= '0;
            consec <= '0;
        end else begin
            hist   <= hist_next;
            consec <= consec_next;
        end
    end

endmodule

// File: rtl/wake_decision_ctrl.sv
// Wake-up decision controller: frame edge detect, count saturation,
// frame statistics, configurable decision modes and ack/hold-off.
module wake_decision_ctrl
    import median_filter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_WIN    = DEF_MAX_WIN,
    parameter int HIST_DEPTH = 8,
    parameter int HOLDOFF_W  = 4,
    localparam int KW        = $clog2(HIST_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 frameDone,
    input  logic [CNT_W-1:0]     activeWindows,
    input  logic [CNT_W-1:0]     thresholdHigh,
    input  logic [CNT_W-1:0]     thresholdLow,
    input  logic [1:0]           mode,
    input  logic [KW-1:0]        requiredFrames,
    input  logic [HOLDOFF_W-1:0] holdoffFrames,
    input  logic                 wakeAck,
    output logic                 wakeUp,
    output logic [CNT_W-1:0]     lastCount,
    output logic [CNT_W-1:0]     peakCount,
    output logic [15:0]          frameCount,
    output logic                 cfgError
);

    state_e               state;
    mode_e                cfg_mode;
    logic [CNT_W-1:0]     th_high;
    logic [CNT_W-1:0]     th_low;
    logic [KW-1:0]        cfg_k;
    logic [HOLDOFF_W-1:0] cfg_hold;
    logic [HOLDOFF_W-1:0] hold_cnt;
    logic                 fd_q;
    logic                 ev_q;
    logic                 clamp_q;
    logic [CNT_W-1:0]     sat_q;

    logic             fe;
    logic             over;
    logic [CNT_W-1:0] sat_in;
    logic             above;
    logic             hit;
    logic             consec_hit;
    logic             kofn_hit;
    logic             ack_go;
    logic             rel_go;
    logic             hold_done;
    logic             enter_armed;
    logic             clear;

    assign fe     = frameDone & ~fd_q;
    assign over   = (activeWindows > CNT_W'(MAX_WIN));
    assign sat_in = over ? CNT_W'(MAX_WIN) : activeWindows;
    assign above  = (sat_q > th_high);

    assign ack_go    = (state == WAKE) && (cfg_mode != MODE_HYST) && wakeAck;
    assign rel_go    = (state == WAKE) && (cfg_mode == MODE_HYST)
                       && ev_q && (sat_q < th_low);
    assign hold_done = (state == HOLDOFF) && ev_q
                       && (hold_cnt == HOLDOFF_W'(1));

    // Any path back into ARMED restarts the history window.
    assign enter_armed = ((state == IDLE) && start)
                         || (ack_go && (cfg_hold == '0))
                         || rel_go || hold_done;
    assign clear = !start || enter_armed;

    always_comb begin
        hit = 1'b0;
        unique case (cfg_mode)
            MODE_CONSEC: hit = consec_hit;
            MODE_KOFN:   hit = kofn_hit;
            default:     hit = above;
        endcase
    end

    frame_history_window #(
        .N  (HIST_DEPTH),
        .KW (KW)
    ) u_hist (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .shiftEn   (ev_q),
        .bitIn     (above),
        .K         (cfg_k),
        .consecHit (consec_hit),
        .kofnHit   (kofn_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cfg_mode   <= MODE_SINGLE;
            th_high    <= '0;
            th_low     <= '0;
            cfg_k      <= '0;
            cfg_hold   <= '0;
            hold_cnt   <= '0;
            fd_q       <= 1'b0;
            ev_q       <= 1'b0;
            clamp_q    <= 1'b0;
            sat_q      <= '0;
            wakeUp     <= 1'b0;
            lastCount  <= '0;
            peakCount  <= '0;
            frameCount <= '0;
            cfgError   <= 1'b0;
        end else if (!start) begin
            state      <= IDLE;
            cfg_mode   <= MODE_SINGLE;
            th_high    <= '0;
            th_low     <= '0;
            cfg_k      <= '0;
            cfg_hold   <= '0;
            hold_cnt   <= '0;
            fd_q       <= 1'b0;
            ev_q       <= 1'b0;
            clamp_q    <= 1'b0;
            sat_q      <= '0;
            wakeUp     <= 1'b0;
            lastCount  <= '0;
            peakCount  <= '0;
            frameCount <= '0;
            cfgError   <= 1'b0;
        end else begin
            // Edges seen while IDLE are swallowed, so a level left high
            // across reset or a start cycle never becomes a frame.
            fd_q    <= frameDone;
            ev_q    <= fe && (state != IDLE);
            sat_q   <= sat_in;
            clamp_q <= over;

            if (ev_q) begin
                lastCount <= sat_q;
                if (sat_q > peakCount) peakCount <= sat_q;
                if (frameCount != 16'hFFFF) frameCount <= frameCount + 16'd1;
                if (clamp_q) cfgError <= 1'b1;
            end

            case (state)
                IDLE: begin
                    state    <= ARMED;
                    th_high  <= thresholdHigh;
                    th_low   <= thresholdLow;
                    cfg_hold <= holdoffFrames;
                    cfg_k    <= KW'(clamp_k(int'(requiredFrames), HIST_DEPTH));
                    if (mode_e'(mode) == MODE_HYST
                        && thresholdLow > thresholdHigh) begin
                        cfg_mode <= MODE_SINGLE;
                        cfgError <= 1'b1;
                    end else begin
                        cfg_mode <= mode_e'(mode);
                    end
                end
                ARMED: begin
                    if (ev_q && hit) begin
                        state  <= WAKE;
                        wakeUp <= 1'b1;
                    end
                end
                WAKE: begin
                    if (ack_go) begin
                        wakeUp   <= 1'b0;
                        hold_cnt <= cfg_hold;
                        state    <= (cfg_hold == '0) ? ARMED : HOLDOFF;
                    end else if (rel_go) begin
                        wakeUp <= 1'b0;
                        state  <= ARMED;
                    end
                end
                HOLDOFF: begin
                    if (ev_q) begin
                        hold_cnt <= hold_cnt - 1'b1;
                        if (hold_done) state <= ARMED;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wake_decision_ctrl.sv
// Directed and randomized checks of wake_decision_ctrl against a
// queue-based frame-history reference model.
module tb_wake_decision_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        frameDone;
    logic [12:0] activeWindows;
    logic [12:0] thresholdHigh;
    logic [12:0] thresholdLow;
    logic [1:0]  mode;
    logic [3:0]  requiredFrames;
    logic [3:0]  holdoffFrames;
    logic        wakeAck;
    logic        wakeUp;
    logic [12:0] lastCount;
    logic [12:0] peakCount;
    logic [15:0] frameCount;
    logic        cfgError;

    int n_assert = 0;
    int n_fail   = 0;

    wake_decision_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .frameDone      (frameDone),
        .activeWindows  (activeWindows),
        .thresholdHigh  (thresholdHigh),
        .thresholdLow   (thresholdLow),
        .mode           (mode),
        .requiredFrames (requiredFrames),
        .holdoffFrames  (holdoffFrames),
        .wakeAck        (wakeAck),
        .wakeUp         (wakeUp),
        .lastCount      (lastCount),
        .peakCount      (peakCount),
        .frameCount     (frameCount),
        .cfgError       (cfgError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Reference model: history is a queue of above-threshold bits,
    // newest first, at most 8 deep.
    int  m_mode, m_k, m_thh, m_thl, m_holdcfg, m_hold;
    int  m_last, m_peak, m_fc;
    bit  m_wake, m_err;
    bit  hist[$];

    function automatic void model_clear();
        m_mode = 0; m_k = 1; m_thh = 0; m_thl = 0;
        m_holdcfg = 0; m_hold = 0;
        m_last = 0; m_peak = 0; m_fc = 0;
        m_wake = 0; m_err = 0;
        hist.delete();
    endfunction

    function automatic void model_cfg();
        m_mode    = int'(mode);
        m_thh     = int'(thresholdHigh);
        m_thl     = int'(thresholdLow);
        m_holdcfg = int'(holdoffFrames);
        if (requiredFrames == 0) m_k = 1;
        else if (requiredFrames > 8) m_k = 8;
        else m_k = int'(requiredFrames);
        if (m_mode == 3 && m_thl > m_thh) begin
            m_err  = 1;
            m_mode = 0;
        end
        m_wake = 0; m_hold = 0;
        hist.delete();
    endfunction

    function automatic void push_hist(bit a);
        hist.push_front(a);
        if (hist.size() > 8) void'(hist.pop_back());
    endfunction

    function automatic int run_len();
        int c = 0;
        for (int i = 0; i < hist.size(); i++) begin
            if (!hist[i]) break;
            c++;
        end
        return c;
    endfunction

    function automatic int ones();
        int c = 0;
        for (int i = 0; i < hist.size(); i++) c += int'(hist[i]);
        return c;
    endfunction

    function automatic void ack_taken();
        m_wake = 0;
        if (m_holdcfg == 0) hist.delete();
        else m_hold = m_holdcfg;
    endfunction

    function automatic void model_ack();
        if (m_wake && m_mode != 3) ack_taken();
    endfunction

    function automatic void model_frame(int v, bit ackd);
        int sat;
        bit a;
        sat = (v > 4800) ? 4800 : v;
        if (v > 4800) m_err = 1;
        m_last = sat;
        if (sat > m_peak) m_peak = sat;
        if (m_fc < 65535) m_fc++;
        a = (sat > m_thh);
        push_hist(a);
        if (m_wake && m_mode == 3) begin
            if (sat < m_thl) begin
                m_wake = 0;
                hist.delete();
            end
        end else if (m_wake) begin
            if (ackd) ack_taken();
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) hist.delete();
        end else begin
            case (m_mode)
                1:       m_wake = (run_len() >= m_k);
                2:       m_wake = (ones() >= m_k);
                default: m_wake = a;
            endcase
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_wake"}, 32'(wakeUp), 32'(m_wake));
        chk({tag, "_last"}, 32'(lastCount), 32'(m_last));
        chk({tag, "_peak"}, 32'(peakCount), 32'(m_peak));
        chk({tag, "_fcnt"}, 32'(frameCount), 32'(m_fc));
        chk({tag, "_err"}, 32'(cfgError), 32'(m_err));
    endtask

    task automatic session(input int md, input int thh, input int thl,
                           input int k, input int hold);
        start = 1'b0;
        @(posedge clk); #1;
        model_clear();
        check_all("stop");
        mode           = md[1:0];
        thresholdHigh  = thh[12:0];
        thresholdLow   = thl[12:0];
        requiredFrames = k[3:0];
        holdoffFrames  = hold[3:0];
        start = 1'b1;
        @(posedge clk); #1;
        model_cfg();
        @(posedge clk); #1;
        check_all("start");
    endtask

    task automatic frame(input int v);
        activeWindows = v[12:0];
        frameDone = 1'b1;
        @(posedge clk); #1;
        chk("lat_pre", 32'(wakeUp), 32'(m_wake));
        @(posedge clk); #1;
        model_frame(v, 1'b0);
        chk("lat_post", 32'(wakeUp), 32'(m_wake));
        frameDone = 1'b0;
        @(posedge clk); #1;
        check_all("frame");
    endtask

    task automatic frame_ack(input int v);
        activeWindows = v[12:0];
        frameDone = 1'b1;
        @(posedge clk); #1;
        wakeAck = 1'b1;
        @(posedge clk); #1;
        wakeAck = 1'b0;
        model_frame(v, 1'b1);
        frameDone = 1'b0;
        @(posedge clk); #1;
        check_all("frame_ack");
    endtask

    task automatic frame_long(input int v, input int cyc);
        activeWindows = v[12:0];
        frameDone = 1'b1;
        repeat (cyc) @(posedge clk);
        #1;
        model_frame(v, 1'b0);
        frameDone = 1'b0;
        @(posedge clk); #1;
        check_all("frame_long");
    endtask

    task automatic ack();
        wakeAck = 1'b1;
        @(posedge clk); #1;
        wakeAck = 1'b0;
        model_ack();
        chk("ack_fall", 32'(wakeUp), 32'(m_wake));
        @(posedge clk); #1;
        check_all("ack");
    endtask

    initial begin
        int md, thh, thl, k, hold, v, r;
        reset = 1'b1; start = 1'b0; frameDone = 1'b0;
        activeWindows = '0; thresholdHigh = '0; thresholdLow = '0;
        mode = '0; requiredFrames = '0; holdoffFrames = '0;
        wakeAck = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // T1 single frame with latency and ack
        session(0, 100, 0, 1, 0);
        frame(50);
        frame(101);
        chk("t1_wake", 32'(wakeUp), 32'd1);
        ack();
        chk("t1_ackd", 32'(wakeUp), 32'd0);

        // T2 K consecutive
        session(1, 100, 0, 3, 0);
        frame(200); frame(200); frame(50);
        frame(200); frame(200);
        chk("t2_nowake", 32'(wakeUp), 32'd0);
        frame(200);
        chk("t2_wake", 32'(wakeUp), 32'd1);
        chk("t2_fcnt", 32'(frameCount), 32'd6);
        chk("t2_peak", 32'(peakCount), 32'd200);
        ack();

        // T3 K of N
        session(2, 100, 0, 3, 0);
        frame(150); frame(50); frame(150); frame(50);
        chk("t3_nowake", 32'(wakeUp), 32'd0);
        frame(150);
        chk("t3_wake", 32'(wakeUp), 32'd1);

        // T4 hysteresis, then inverted thresholds fall back to single
        session(3, 100, 40, 1, 0);
        frame(150);
        frame(60);
        ack();
        chk("t4_held", 32'(wakeUp), 32'd1);
        frame(30);
        chk("t4_rel", 32'(wakeUp), 32'd0);
        session(3, 100, 120, 1, 0);
        chk("t4_cfgerr", 32'(cfgError), 32'd1);
        frame(110);
        ack();
        chk("t4_m0ack", 32'(wakeUp), 32'd0);

        // T5 hold-off and held frameDone
        session(0, 100, 0, 1, 2);
        frame(300);
        ack();
        frame(300); frame(300);
        chk("t5_hold", 32'(wakeUp), 32'd0);
        frame(300);
        chk("t5_wake", 32'(wakeUp), 32'd1);
        ack();
        frame_long(300, 10);
        chk("t5_long", 32'(frameCount), 32'd5);
        frame(300);
        frame(300);
        frame_ack(300);
        chk("t5_simack", 32'(wakeUp), 32'd0);

        // T6 saturation, async reset, start drop with frame
        session(0, 100, 0, 1, 0);
        frame(8000);
        chk("t6_sat", 32'(lastCount), 32'd4800);
        chk("t6_err", 32'(cfgError), 32'd1);
        activeWindows = 13'd300;
        frameDone = 1'b1;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_clear();
        model_cfg();
        repeat (4) @(posedge clk);
        #1;
        check_all("t6_areset");
        frameDone = 1'b0;
        @(posedge clk); #1;
        frameDone = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        model_clear();
        check_all("t6_stopfe");
        start = 1'b1;
        @(posedge clk); #1;
        model_cfg();
        repeat (3) @(posedge clk);
        #1;
        frameDone = 1'b0;
        check_all("t6_dropped");

        // Randomized episodes; config pins scrambled after the latch
        for (int ep = 0; ep < 6; ep++) begin
            md   = int'($urandom % 4);
            thh  = int'($urandom_range(200, 3000));
            thl  = int'($urandom_range(0, 3500));
            k    = int'($urandom % 16);
            hold = int'($urandom % 4);
            session(md, thh, thl, k, hold);
            thresholdHigh  = 13'($urandom % 4800);
            thresholdLow   = 13'($urandom % 4800);
            mode           = 2'($urandom);
            requiredFrames = 4'($urandom);
            holdoffFrames  = 4'($urandom);
            for (int s = 0; s < 40; s++) begin
                r = int'($urandom % 10);
                if ($urandom % 12 == 0) v = 8000;
                else v = int'($urandom_range(0, 2 * thh));
                if (r == 0) ack();
                else if (r == 1) frame_ack(v);
                else frame(v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
